fifo_read_ctrl: RTL

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_read_ctrl_if.sv | 30 +++
 rtl/fifo_read_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/fifo_read_ctrl_if.sv
// Handshake bundle between a read-side FIFO, the read controller and its downstream consumer.
// The controller attaches through the slave modport; the stimulus/host side uses master.
interface fifo_read_ctrl_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned CNTW  = 8
) ();
  logic             start;
  logic [CNTW-1:0]  len;
  logic             abort;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNTW-1:0]  rd_count;

  modport slave (
    input  start, len, abort, rempty, rdata, out_ready,
    output rinc, out_data, out_valid, busy, done, aborted, rd_count
  );

  modport master (
    output start, len, abort, rempty, rdata, out_ready,
    input  rinc, out_data, out_valid, busy, done, aborted, rd_count
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Reads a requested number of words out of a FIFO into a 2-entry skid buffer and
// presents them downstream with a valid/ready handshake; supports abort.
module fifo_read_ctrl #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned CNTW  = 8
) (
  input logic              rclk,
  input logic              rrst_n,
  fifo_read_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [CNTW-1:0]  remaining_q, len_q, rd_count_q, rem_d;
  logic             aborted_q;
  logic [DSIZE-1:0] buf_q [2];
  logic [1:0]       cnt_q, cnt_d, wr_pos;
  logic             hs, room, rinc, wr_idx;

  assign hs   = (cnt_q != 2'd0) && bus.out_ready;
  // A full buffer still has room if its head leaves this cycle.
  assign room = (cnt_q != 2'd2) || hs;
  assign rinc = (state_q == StRun) && !bus.rempty && (remaining_q != '0) && room && !bus.abort;

  always_comb begin
    cnt_d  = cnt_q + {1'b0, rinc} - {1'b0, hs};
    rem_d  = remaining_q - CNTW'(rinc);
    wr_pos = cnt_q - {1'b0, hs};
    wr_idx = wr_pos[0];
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      len_q       <= '0;
      rd_count_q  <= '0;
      aborted_q   <= 1'b0;
      cnt_q       <= 2'd0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      if (hs) begin
        buf_q[0] <= buf_q[1];
        if (rd_count_q != len_q) rd_count_q <= rd_count_q + CNTW'(1);
      end
      // Placed after the shift so a push into the slot just vacated wins.
      if (rinc) buf_q[wr_idx] <= bus.rdata;

      case (state_q)
        StIdle: begin
          if (bus.start) begin
            rd_count_q  <= '0;
            aborted_q   <= 1'b0;
            len_q       <= bus.len;
            remaining_q <= bus.len;
            state_q     <= (bus.len == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (bus.abort) begin
            cnt_q       <= 2'd0;
            remaining_q <= '0;
            aborted_q   <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q       <= cnt_d;
            remaining_q <= rem_d;
            if (rem_d == '0) state_q <= (cnt_d == 2'd0) ? StDone : StDrain;
          end
        end
        StDrain: begin
          if (bus.abort) begin
            cnt_q     <= 2'd0;
            aborted_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == 2'd0) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rinc      = rinc;
  assign bus.out_data  = buf_q[0];
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.busy      = (state_q == StRun) || (state_q == StDrain);
  assign bus.done      = (state_q == StDone);
  assign bus.aborted   = aborted_q;
  assign bus.rd_count  = rd_count_q;

endmodule
